// File: rtl/axi_mem_slave.sv
// AXI4-Lite memory slave: DEPTH x 32-bit RAM with big-endian byte lanes and
// independent read and write channel FSMs.
module axi_mem_slave #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,

    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    logic [31:0] mem [DEPTH];

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic        out_en_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic        commit_q, commit_d;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    function automatic logic out_of_range(input logic [31:0] addr);
        return (addr >> (AW + 2)) != '0;
    endfunction

    // Readys are held low until the first edge after reset so they depend on state only.
    assign s_axi_arready = out_en_q && (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_awready = out_en_q && (w_state_q != W_RESP) && !aw_got_q;
    assign s_axi_wready  = out_en_q && (w_state_q != W_RESP) && !w_got_q;
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = (s_axi_bvalid && out_of_range(awaddr_q)) ? 2'b10 : 2'b00;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE: if (ar_hs) r_state_d = R_DATA;
            R_DATA: if (r_hs) r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        commit_d  = 1'b0;
        unique case (w_state_q)
            W_IDLE, W_WAIT: begin
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    w_state_d = W_RESP;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    commit_d  = 1'b1;
                end else if (aw_hs || w_hs) begin
                    w_state_d = W_WAIT;
                    aw_got_d  = aw_got_q || aw_hs;
                    w_got_d   = w_got_q || w_hs;
                end
            end
            W_RESP: if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            out_en_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            out_en_q  <= 1'b1;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            commit_q  <= commit_d;
            // Sampled on the same edge a commit lands, so a colliding read sees old data.
            if (ar_hs) begin
                if (out_of_range(s_axi_araddr)) begin
                    rdata_q <= '0;
                    rresp_q <= 2'b10;
                end else begin
                    rdata_q <= mem[s_axi_araddr[AW+1:2]];
                    rresp_q <= 2'b00;
                end
            end
            if (aw_hs) awaddr_q <= s_axi_awaddr;
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
        end
    end

    // Word bits [31:24] hold byte offset 0, so strobe lanes map straight onto word lanes.
    always_ff @(posedge clk) begin
        if (commit_q && !out_of_range(awaddr_q)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[awaddr_q[AW+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized self-checking bench for axi_mem_slave against a byte-level
// behavioural model of the AXI-Lite memory.
module tb_axi_mem_slave;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LIMIT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    axi_mem_slave #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within %0d cycles at %0t", name, LIMIT, $time);
    endtask

    // Behavioural model: memory as a byte array indexed by byte offset.
    logic [7:0]  mem_b [DEPTH*4];
    bit          m_en, r_busy, aw_have, w_have, b_pend, c_pend;
    logic [31:0] m_rdata, aw_a, w_d;
    logic [1:0]  m_rresp;
    logic [3:0]  w_s;
    bit          ar_ok, aw_ok, w_ok;

    function automatic bit oob(input logic [31:0] a);
        return (a >> (AW + 2)) != 0;
    endfunction

    function automatic int base_of(input logic [31:0] a);
        return int'((a >> 2) & (DEPTH - 1)) * 4;
    endfunction

    function automatic logic [31:0] read_word(input logic [31:0] a);
        int b;
        b = base_of(a);
        return {mem_b[b], mem_b[b+1], mem_b[b+2], mem_b[b+3]};
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_en = 0; r_busy = 0; aw_have = 0; w_have = 0; b_pend = 0; c_pend = 0;
        end else begin
            ar_ok = arvalid && m_en && !r_busy;
            aw_ok = awvalid && m_en && !b_pend && !aw_have;
            w_ok  = wvalid && m_en && !b_pend && !w_have;
            if (r_busy && rready) r_busy = 0;
            if (ar_ok) begin
                r_busy  = 1;
                m_rdata = oob(araddr) ? 32'h0 : read_word(araddr);
                m_rresp = oob(araddr) ? 2'b10 : 2'b00;
            end
            if (b_pend && bready) b_pend = 0;
            if (c_pend) begin
                c_pend = 0;
                if (!oob(aw_a))
                    for (int o = 0; o < 4; o++)
                        if (w_s[3-o]) mem_b[base_of(aw_a) + o] = w_d[31-8*o -: 8];
            end
            if (aw_ok) begin aw_have = 1; aw_a = awaddr; end
            if (w_ok) begin w_have = 1; w_d = wdata; w_s = wstrb; end
            if (aw_have && w_have) begin
                b_pend = 1; c_pend = 1; aw_have = 0; w_have = 0;
            end
            m_en = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (rst) begin
                chk("rst_arready", arready, 0);
                chk("rst_rvalid", rvalid, 0);
                chk("rst_rdata", rdata, 0);
                chk("rst_rresp", rresp, 0);
                chk("rst_awready", awready, 0);
                chk("rst_wready", wready, 0);
                chk("rst_bvalid", bvalid, 0);
                chk("rst_bresp", bresp, 0);
            end else begin
                chk("arready", arready, m_en && !r_busy);
                chk("rvalid", rvalid, r_busy);
                if (r_busy) begin
                    chk("rdata", rdata, m_rdata);
                    chk("rresp", rresp, m_rresp);
                end
                chk("awready", awready, m_en && !b_pend && !aw_have);
                chk("wready", wready, m_en && !b_pend && !w_have);
                chk("bvalid", bvalid, b_pend);
                if (b_pend) chk("bresp", bresp, oob(aw_a) ? 2'b10 : 2'b00);
            end
        end
    end

    // Channel drivers: entered just after a rising edge, leave just after one.
    task automatic send_aw(input logic [31:0] a);
        awaddr = a; awvalid = 1'b1;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (awready) begin @(posedge clk); #1; awvalid = 1'b0; return; end
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        fail_timeout("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (wready) begin @(posedge clk); #1; wvalid = 1'b0; return; end
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        fail_timeout("w_handshake");
    endtask

    task automatic send_ar(input logic [31:0] a);
        araddr = a; arvalid = 1'b1;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (arready) begin @(posedge clk); #1; arvalid = 1'b0; return; end
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        fail_timeout("ar_handshake");
    endtask

    task automatic get_b(output logic [1:0] resp);
        resp = 2'bxx; bready = 1'b1;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (bvalid) begin resp = bresp; @(posedge clk); #1; bready = 1'b0; return; end
            @(posedge clk); #1;
        end
        bready = 1'b0;
        fail_timeout("b_handshake");
    endtask

    task automatic get_r(input int hold, output logic [31:0] data, output logic [1:0] resp,
                         output int lat);
        lat = 0; data = 'x; resp = 'x;
        for (int n = 1; n <= LIMIT; n++) begin
            @(negedge clk);
            if (rvalid) begin lat = n; break; end
            @(posedge clk); #1;
        end
        if (lat == 0) begin fail_timeout("r_valid"); return; end
        for (int h = 0; h < hold; h++) begin
            chk("hold_arready", arready, 0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        rready = 1'b1; data = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, output logic [1:0] resp);
        fork
            begin repeat (lead > 0 ? lead : 0) begin @(posedge clk); #1; end send_aw(a); end
            begin repeat (lead < 0 ? -lead : 0) begin @(posedge clk); #1; end send_w(d, s); end
        join
        get_b(resp);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        send_ar(a);
        get_r(hold, data, resp, lat);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_0040;
        return ($urandom_range(0, DEPTH - 1) << 2) | ($urandom & 32'd3);
    endfunction

    initial begin
        logic [31:0] d, wa, ra, wd;
        logic [1:0]  rr, br;
        logic [3:0]  ws;
        int          lat, lead, hold, mode, gap;

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        chk("reset_arready", arready, 0);
        chk("reset_bvalid", bvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", arready, 0);
        @(posedge clk); #1;
        chk("first_edge_arready", arready, 1);
        chk("first_edge_awready", awready, 1);
        chk("first_edge_wready", wready, 1);

        for (int i = 0; i < DEPTH; i++) do_write(i * 4, 32'h0, 4'hF, 0, br);

        do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, br);
        chk("s1_bresp", br, 2'b00);
        do_read(32'h10, 0, d, rr, lat);
        chk("s1_rdata", d, 32'hDEAD_BEEF);
        chk("s1_rresp", rr, 2'b00);
        chk("s1_latency", lat, 1);

        do_write(32'h10, 32'h1122_3344, 4'b1000, 3, br);
        chk("s2_bresp", br, 2'b00);
        do_read(32'h10, 0, d, rr, lat);
        chk("s2_rdata", d, 32'h11AD_BEEF);

        do_write(32'h12, 32'hFFFF_FFFF, 4'b0000, -1, br);
        chk("nostrb_bresp", br, 2'b00);
        do_read(32'h13, 0, d, rr, lat);
        chk("nostrb_rdata", d, 32'h11AD_BEEF);

        do_write(4 * DEPTH, 32'hCAFE_F00D, 4'hF, 0, br);
        chk("s3_bresp", br, 2'b10);
        do_read(4 * DEPTH, 0, d, rr, lat);
        chk("s3_rdata", d, 32'h0);
        chk("s3_rresp", rr, 2'b10);
        do_read(32'h0, 0, d, rr, lat);
        chk("s3_word0", d, 32'h0);

        do_read(32'h10, 5, d, rr, lat);
        chk("s4_rdata", d, 32'h11AD_BEEF);

        fork
            do_write(32'h20, 32'hA5A5_A5A5, 4'hF, 0, br);
            begin @(posedge clk); #1; do_read(32'h20, 0, d, rr, lat); end
        join
        chk("s5_old_data", d, 32'h0);
        do_read(32'h20, 0, d, rr, lat);
        chk("s5_new_data", d, 32'hA5A5_A5A5);

        send_aw(32'h24);
        rst = 1'b1;
        #1;
        chk("s6_rst_bvalid", bvalid, 0);
        chk("s6_rst_awready", awready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s6_no_bvalid", bvalid, 0);
        end
        @(posedge clk); #1;
        do_write(32'h24, 32'h1234_5678, 4'hF, 0, br);
        chk("s6_bresp", br, 2'b00);
        do_read(32'h24, 0, d, rr, lat);
        chk("s6_rdata", d, 32'h1234_5678);
        do_read(32'h20, 0, d, rr, lat);
        chk("s6_mem_kept", d, 32'hA5A5_A5A5);

        for (int it = 0; it < 200; it++) begin
            wa = rand_addr(); ra = rand_addr(); wd = $urandom; ws = 4'($urandom);
            lead = int'($urandom_range(0, 6)) - 3;
            hold = int'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 2));
            mode = int'($urandom_range(0, 2));
            case (mode)
                0: do_write(wa, wd, ws, lead, br);
                1: do_read(ra, hold, d, rr, lat);
                default: fork
                    do_write(wa, wd, ws, lead, br);
                    begin repeat (gap) begin @(posedge clk); #1; end do_read(ra, hold, d, rr, lat); end
                join
            endcase
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 The block SHALL be clocked by a single clock; reset is asynchronous and active-high.
REQ-002 Parameter: DEPTH, default 1024, memory size in 32-bit words (power of two).
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- s_axi_araddr  in  32  read byte address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  32  read data, big endian.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_awaddr  in  32  write byte address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  32  write data, big endian.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.

Function
REQ-004 Transfers SHALL occur when valid and ready are both high on a rising clk edge; ready SHALL NOT depend combinationally on valid.
REQ-005 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored.
REQ-006 An address with any bit at or above log2(DEPTH)+2 set SHALL be out-of-range: response 2'b10 (SLVERR), rdata 32'h0, no memory update; in-range response SHALL be 2'b00.
REQ-007 Byte order SHALL be big endian: wstrb[3] writes wdata[31:24] to byte offset 0, ..., wstrb[0] writes wdata[7:0] to offset 3.
REQ-008 The read FSM SHALL have states R_IDLE and R_DATA:
- R_IDLE: arready=1. On an AR handshake it latches the address and goes to R_DATA.
- R_DATA: arready=0, rvalid=1 starting the cycle after the handshake (1-cycle latency). rdata/rresp hold stable until the R handshake, then the FSM returns to R_IDLE.
REQ-009 The write FSM SHALL have states W_IDLE, W_WAIT, and W_RESP:
- W_IDLE: awready=1 and wready=1. AW and W are accepted independently in either order or the same cycle. Each ready drops after its own handshake.
- W_WAIT: holds until both AW and W have been captured.
- The memory commit SHALL occur on the cycle after the second capture. bvalid rises that same cycle with bresp.
- W_RESP: bvalid holds until the B handshake, then the FSM returns to W_IDLE with both readys high the next cycle.
REQ-010 Read and write FSMs SHALL operate concurrently. A read that samples memory in the same cycle as a write commit to the same word SHALL return the pre-write data.
REQ-011 Back-to-back reads SHALL sustain one transfer per 2 cycles. A new AR SHALL NOT be accepted while rvalid=1.
REQ-012 wstrb=4'b0000 in range SHALL complete with OKAY and leave memory unchanged.

Reset
REQ-013 While rst=1, every output SHALL be 0 and both FSMs SHALL be in their IDLE state.
REQ-014 arready, awready, and wready SHALL rise on the first clk edge after rst deasserts.
REQ-015 Memory contents SHALL NOT be reset.
REQ-016 Reset asserted mid-transaction SHALL abort it immediately with no partial write and no response issued after reset.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Write 0x0000_0010 data 0xDEADBEEF wstrb 4'hF, AW and W in the same cycle, then read 0x10 -> bresp 00; rdata 0xDEADBEEF, rresp 00, rvalid one cycle after the AR handshake.
- W precedes AW by 3 cycles, wstrb 4'b1000, data 0x11223344 to a word holding 0xDEADBEEF -> read returns 0x11ADBEEF.
- Read and write to address 4*DEPTH -> rresp 10 with rdata 0; bresp 10; word 0 unchanged.
- rready held low 5 cycles after rvalid -> rdata stable, arready 0 throughout, then one R handshake.
- Read of word 8 issued the same cycle its write commits (old 0x0, new 0xA5A5A5A5) -> returns 0x0; a later read returns 0xA5A5A5A5.
- rst pulsed after AW accepted but before W -> no bvalid; the following write/read pair completes normally.
